// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem request at a time,
// buffers returned words in a small FIFO and hands them to decode with pre-split fields.
`timescale 1ns/1ps

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        op5,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]  DEPTH_CNT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]     PC_INIT   = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]      pc;
    logic [31:0]      fetch_pc;
    logic [31:0]      target_pc;
    logic [31:0]      buf_instr [FIFO_DEPTH];
    logic [31:0]      buf_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             in_flight;
    logic             credit;
    logic             push;
    logic             pop;
    logic             granted;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign in_flight = (state == WAIT) || (state == DROP);
    // Credit counts the request already in flight so a buffered slot is reserved before fetching.
    assign credit    = ({1'b0, count} + {{CNT_W{1'b0}}, in_flight}) < DEPTH_CNT;
    assign granted   = (state == REQ) && imem_gnt;
    assign pop       = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (credit) state_next = REQ;
            end
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_next = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push       = 1'b1;
                    state_next = credit ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_rvalid) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
        // A redirect overrides everything; any granted-but-unreturned request becomes a stale response to drop.
        if (redirect) begin
            push = 1'b0;
            case (state)
                IDLE:    state_next = REQ;
                REQ:     state_next = imem_gnt ? DROP : REQ;
                WAIT:    state_next = imem_rvalid ? REQ : DROP;
                DROP:    state_next = imem_rvalid ? REQ : DROP;
                default: state_next = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= PC_INIT;
            fetch_pc <= '0;
        end else if (redirect) begin
            pc <= target_pc;
        end else if (granted) begin
            pc       <= pc + 32'd4;
            fetch_pc <= pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= fetch_pc;
        end
    end

    assign imem_addr      = imem_req ? pc : 32'd0;
    assign instr_valid    = (count != '0);
    assign instr          = instr_valid ? buf_instr[rd_ptr] : 32'd0;
    assign instr_pc       = instr_valid ? buf_pc[rd_ptr] : 32'd0;
    assign instr_pc_plus4 = instr_valid ? (buf_pc[rd_ptr] + 32'd4) : 32'd0;
    assign op             = instr[6:0];
    assign funct3         = instr[14:12];
    assign funct7         = instr[30];
    assign op5            = instr[5];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected deliveries,
// a monitor pops and compares every word decode accepts.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic        funct7;
        logic        op5;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        op5;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        gnt_en;
    int          mem_lat;
    int          grants = 0;
    int          tests = 0;
    int          failures = 0;
    logic [31:0] gnt_q[$];
    exp_t        sb_q[$];

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .op5            (op5),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    assign imem_gnt = imem_req & gnt_en;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0200: mem_word = 32'h40B5_0533;
            32'h0000_0204: mem_word = 32'h00B5_0463;
            default:       mem_word = addr;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [31:0] addr);
        exp_t e;
        e.instr  = addr;
        e.pc     = addr;
        e.pc4    = addr + 32'd4;
        e.op     = addr[6:0];
        e.funct3 = addr[14:12];
        e.funct7 = addr[30];
        e.op5    = addr[5];
        sb_q.push_back(e);
    endtask

    task automatic push_entry(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] pc4,
                              input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic o5);
        exp_t e;
        e.instr  = w;
        e.pc     = pc;
        e.pc4    = pc4;
        e.op     = o;
        e.funct3 = f3;
        e.funct7 = f7;
        e.op5    = o5;
        sb_q.push_back(e);
    endtask

    task automatic apply_reset(input int lat);
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        gnt_en      = 1'b1;
        instr_ready = 1'b0;
        mem_lat     = lat;
        tick(2);
        check_output("reset_imem_req", {31'd0, imem_req}, 32'd0);
        check_output("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
        check_output("reset_instr", instr, 32'd0);
        check_output("reset_instr_pc", instr_pc, 32'd0);
        check_output("reset_pc_plus4", instr_pc_plus4, 32'd0);
        check_output("reset_op", {25'd0, op}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic wait_grants(input string name, input int base, input int n);
        for (int i = 0; i < 300 && (grants - base) < n; i++) tick();
        check_output(name, {31'd0, (grants - base) >= n}, 32'd1);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
        check_output(name, sb_q.size(), 32'd0);
        tick(4);
    endtask

    task automatic wait_req(input string name, input logic [31:0] addr);
        for (int i = 0; i < 50 && !imem_req; i++) tick();
        check_output(name, imem_addr, addr);
    endtask

    // Memory side: grants are sampled mid-cycle, responses return mem_lat cycles later in order.
    always @(negedge clk) begin
        if (!reset && imem_req && imem_gnt) begin
            gnt_q.push_back(imem_addr);
            grants++;
        end
    end

    initial begin : responder
        logic        busy;
        logic [31:0] busy_addr;
        int          wait_cnt;
        busy        = 1'b0;
        busy_addr   = 32'd0;
        wait_cnt    = 0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
            if (reset) begin
                busy = 1'b0;
                gnt_q.delete();
            end else begin
                if (!busy && gnt_q.size() > 0) begin
                    busy_addr = gnt_q.pop_front();
                    busy      = 1'b1;
                    wait_cnt  = mem_lat;
                end
                if (busy) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = mem_word(busy_addr);
                        busy        = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_delivery: got pc %h, expected no delivery", instr_pc);
                end else begin
                    e = sb_q.pop_front();
                    check_output("sb_instr", instr, e.instr);
                    check_output("sb_instr_pc", instr_pc, e.pc);
                    check_output("sb_pc_plus4", instr_pc_plus4, e.pc4);
                    check_output("sb_op", {25'd0, op}, {25'd0, e.op});
                    check_output("sb_funct3", {29'd0, funct3}, {29'd0, e.funct3});
                    check_output("sb_funct7", {31'd0, funct7}, {31'd0, e.funct7});
                    check_output("sb_op5", {31'd0, op5}, {31'd0, e.op5});
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int base;

        // Streaming at full rate: words come back equal to their address.
        apply_reset(1);
        instr_ready = 1'b1;
        base = grants;
        for (int k = 0; k < 8; k++) push_word(32'(k * 4));
        wait_grants("stream_grants", base, 8);
        gnt_en = 1'b0;
        wait_drain("stream_drain");

        // Backpressure: two words buffer up, fetching stops, head holds steady.
        apply_reset(1);
        base = grants;
        tick(12);
        check_output("stall_grants", grants - base, 32'd2);
        check_output("stall_imem_req", {31'd0, imem_req}, 32'd0);
        check_output("stall_valid", {31'd0, instr_valid}, 32'd1);
        check_output("stall_head_pc", instr_pc, 32'd0);
        tick(3);
        check_output("stall_head_pc_hold", instr_pc, 32'd0);
        check_output("stall_head_instr_hold", instr, 32'd0);
        check_output("stall_pc_plus4", instr_pc_plus4, 32'd4);
        push_word(32'h0);
        push_word(32'h4);
        push_word(32'h8);
        instr_ready = 1'b1;
        wait_grants("stall_grants_after", base, 3);
        gnt_en = 1'b0;
        wait_drain("stall_drain");

        // Redirect while a response is still outstanding: stale word dropped.
        apply_reset(3);
        instr_ready = 1'b1;
        push_word(32'h100);
        push_word(32'h104);
        base = grants;
        wait_grants("redir_wait_grant", base, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect    = 1'b0;
        check_output("redir_drop_req", {31'd0, imem_req}, 32'd0);
        wait_req("redir_target_addr", 32'h100);
        wait_grants("redir_grants", base, 3);
        gnt_en = 1'b0;
        wait_drain("redir_drain");

        // Redirect coinciding with rvalid, one word buffered: flush and discard.
        apply_reset(1);
        push_word(32'h300);
        push_word(32'h304);
        base = grants;
        wait_grants("flush_grants", base, 2);
        check_output("flush_valid_before", {31'd0, instr_valid}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect    = 1'b0;
        check_output("flush_valid_after", {31'd0, instr_valid}, 32'd0);
        check_output("flush_req", {31'd0, imem_req}, 32'd1);
        check_output("flush_addr", imem_addr, 32'h300);
        instr_ready = 1'b1;
        wait_grants("flush_grants_after", base, 4);
        gnt_en = 1'b0;
        wait_drain("flush_drain");

        // Decoder fields for sub and beq.
        apply_reset(1);
        instr_ready = 1'b1;
        push_entry(32'h40B5_0533, 32'h200, 32'h204, 7'h33, 3'h0, 1'b1, 1'b1);
        push_entry(32'h00B5_0463, 32'h204, 32'h208, 7'h63, 3'h0, 1'b0, 1'b1);
        base = grants;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect    = 1'b0;
        wait_grants("fields_grants", base, 2);
        gnt_en = 1'b0;
        wait_drain("fields_drain");

        // PC wrap at the top of the address space.
        apply_reset(1);
        instr_ready = 1'b1;
        push_entry(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 7'h7C, 3'h7, 1'b1, 1'b1);
        push_entry(32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 7'h00, 3'h0, 1'b0, 1'b0);
        base = grants;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect    = 1'b0;
        check_output("wrap_first_addr", imem_addr, 32'hFFFF_FFFC);
        wait_grants("wrap_grants", base, 2);
        gnt_en = 1'b0;
        wait_drain("wrap_drain");

        // Reset in the middle of a transaction restarts cleanly from RESET_PC.
        apply_reset(3);
        base = grants;
        wait_grants("midreset_grant", base, 1);
        apply_reset(1);
        instr_ready = 1'b1;
        push_word(32'h0);
        wait_req("midreset_restart_addr", 32'h0);
        base = grants;
        wait_grants("midreset_grants", base, 1);
        gnt_en = 1'b0;
        wait_drain("midreset_drain");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the main/ALU control decoder.
- Owns the PC register and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake, along with pre-split opcode/funct fields for the control unit.
- Accepts taken-branch redirects; on a redirect it flushes all wrong-path words.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch word address; bits[1:0] always 0.
- imem_gnt  in  1  memory accepted request this cycle.
- imem_rvalid  in  1  read data valid; at most one per granted request, in order, at least 1 cycle after gnt.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  decode consumes head.
- instr  out  32  head instruction.
- instr_pc  out  32  PC of head instruction.
- instr_pc_plus4  out  32  instr_pc + 4, wrapping mod 2^32.
- op  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  1  instr[30].
- op5  out  1  instr[5].
- redirect  in  1  taken branch (PCSrc).
- redirect_pc  in  32  branch target; bits[1:0] ignored and forced to 0.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, state=IDLE. All outputs 0 during reset (imem_req=0, instr_valid=0, instr/instr_pc/fields=0, instr_pc_plus4=0).
- FSM states:
  - IDLE: imem_req=0. Go to REQ when credit is available (FIFO occupancy + in-flight < FIFO_DEPTH).
  - REQ: imem_req=1, imem_addr=pc. On gnt: pc<=pc+4, go to WAIT.
  - WAIT: on rvalid, push {rdata, fetched pc} into the FIFO, then go to REQ if credit is available, else IDLE.
  - DROP: discard the next rvalid, then go to REQ.
- Single outstanding request maximum; in-flight = (state==WAIT or DROP).
- Credit is computed from registered occupancy; a same-cycle pop does not free credit until the next cycle.
- Latency: a response that lands in an empty FIFO gives instr_valid=1 on the cycle after the rvalid edge. Best-case sustained throughput is one instruction per 2 cycles.
- FIFO: push on accepted response, pop on instr_valid & instr_ready.
  - Push and pop in the same cycle is allowed when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - Outputs are driven from the head entry and are stable while instr_valid & ~instr_ready.
- Field outputs (op, funct3, funct7, op5) are pure slices of instr; they are 0 when the FIFO is empty.
- Redirect (highest priority, any state):
  - pc <= {redirect_pc[31:2],2'b00}; FIFO flushed, so instr_valid=0 next cycle; any same-cycle pop is ignored.
  - From IDLE or REQ without gnt: go to REQ with the new address next cycle (a pending ungranted request is retargeted).
  - From REQ with gnt the same cycle: go to DROP.
  - From WAIT without rvalid: go to DROP.
  - From WAIT with rvalid the same cycle: the response is discarded; go to REQ.
  - From DROP: stay in DROP (still one stale response owed).
- PC wrap: 32'hFFFF_FFFC + 4 becomes 0 with no error.
- Reset asserted mid-transaction: all state is cleared immediately. The memory side must discard its own outstanding response (system-level requirement).

Test Plan:
- Reset release, RESET_PC=0, gnt tied 1, rvalid 1 cycle after gnt, instr_ready=1, memory returns word=addr → instr_pc sequence 0,4,8,…; instr equals instr_pc; instr_pc_plus4 = instr_pc+4.
- Hold instr_ready=0 with DEPTH=2 → exactly 2 words buffered, imem_req stays 0; head stays addr 0 with stable outputs. Release ready → 0,4,8 delivered with no loss or duplication.
- Redirect to 32'h0000_0103 while in WAIT → next imem_addr=0x100. Stale rvalid is dropped; first delivered instr_pc=0x100.
- Redirect and rvalid in the same WAIT cycle, FIFO holding 1 entry → FIFO empty next cycle, the response is not pushed, next request is at the target.
- Head word 32'h40B50533 (sub) → op=7'h33, funct3=0, funct7=1, op5=1. Head word 32'h00B50463 (beq) → op=7'h63, funct3=0.
- RESET_PC=32'hFFFF_FFFC → first two fetches at 0xFFFFFFFC then 0x0; instr_pc_plus4 of the first instruction = 0.
